// File: rtl/job_ctrl_fsm.sv
// Go/kill job controller: latches len on go, counts len+1 ACTIVE cycles, then FINISH or ABORT.
// Optional PAUSE state compiled in with `define JOB_CTRL_PAUSE_EN; otherwise the pause input is ignored.
module job_ctrl_fsm #(
  parameter int CNT_W  = 8,
  parameter int JCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              kill,
  input  logic              pause,
  input  logic [CNT_W-1:0]  len,
  output logic [2:0]        state,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  count,
  output logic [JCNT_W-1:0] jobs_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACTIVE = 3'd1;
  localparam logic [2:0] S_FINISH = 3'd2;
  localparam logic [2:0] S_ABORT  = 3'd3;
  localparam logic [2:0] S_PAUSE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [JCNT_W-1:0] jobs_q, jobs_d;

`ifndef JOB_CTRL_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    jobs_d  = jobs_q;
    case (state_q)
      S_IDLE: begin
        if (go && !kill) begin
          state_d = S_ACTIVE;
          len_d   = len;
          count_d = '0;
        end
      end
      S_ACTIVE: begin
        if (kill) begin
          state_d = S_ABORT;
`ifdef JOB_CTRL_PAUSE_EN
        end else if (pause) begin
          state_d = S_PAUSE;
`endif
        end else if (count_q == len_q) begin
          // count stops at len_q, so it can never wrap
          state_d = S_FINISH;
          jobs_d  = jobs_q + JCNT_W'(1);
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ABORT: begin
        if (!kill) state_d = S_IDLE;
      end
`ifdef JOB_CTRL_PAUSE_EN
      S_PAUSE: begin
        if (kill)        state_d = S_ABORT;
        else if (!pause) state_d = S_ACTIVE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      len_q   <= '0;
      jobs_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      jobs_q  <= jobs_d;
    end
  end

  assign state     = state_q;
`ifdef JOB_CTRL_PAUSE_EN
  assign busy      = (state_q == S_ACTIVE) || (state_q == S_PAUSE);
`else
  assign busy      = (state_q == S_ACTIVE);
`endif
  assign done      = (state_q == S_FINISH);
  assign aborted   = (state_q == S_ABORT);
  assign count     = count_q;
  assign jobs_done = jobs_q;

endmodule
